// File: rtl/eth_reg_pkg.sv
// Shared types and constants for the Ethernet Lite register arbiter.
// Holds the FSM state encoding, the AXI response codes and the requester count.
package eth_reg_pkg;

   localparam int NUM_REQ = 2;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/eth_reg_arbiter_if.sv
// Bundles for the arbiter: the two-requester command/response bus and the
// AXI-Lite master bus toward the Ethernet Lite register block.
interface eth_req_if #(
   parameter int P_AXI_ADDR_WIDTH = 13,
   parameter int P_AXI_DATA_WIDTH = 32
);
   logic [eth_reg_pkg::NUM_REQ-1:0]                      req_valid;
   logic [eth_reg_pkg::NUM_REQ-1:0]                      req_ready;
   logic [eth_reg_pkg::NUM_REQ-1:0]                      req_write;
   logic [eth_reg_pkg::NUM_REQ*P_AXI_ADDR_WIDTH-1:0]     req_addr;
   logic [eth_reg_pkg::NUM_REQ*P_AXI_DATA_WIDTH-1:0]     req_wdata;
   logic [eth_reg_pkg::NUM_REQ*(P_AXI_DATA_WIDTH/8)-1:0] req_wstrb;
   logic [eth_reg_pkg::NUM_REQ-1:0]                      rsp_valid;
   logic [P_AXI_DATA_WIDTH-1:0]                          rsp_rdata;
   logic [1:0]                                           rsp_resp;
   logic                                                 busy;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb,
      input  req_ready, rsp_valid, rsp_rdata, rsp_resp, busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
      output req_ready, rsp_valid, rsp_rdata, rsp_resp, busy
   );
endinterface

interface eth_axil_if #(
   parameter int P_AXI_ADDR_WIDTH = 13,
   parameter int P_AXI_DATA_WIDTH = 32
);
   logic [P_AXI_ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]                    awprot;
   logic                          awvalid;
   logic                          awready;
   logic [P_AXI_DATA_WIDTH-1:0]   wdata;
   logic [P_AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                          wvalid;
   logic                          wready;
   logic [1:0]                    bresp;
   logic                          bvalid;
   logic                          bready;
   logic [P_AXI_ADDR_WIDTH-1:0]   araddr;
   logic [2:0]                    arprot;
   logic                          arvalid;
   logic                          arready;
   logic [P_AXI_DATA_WIDTH-1:0]   rdata;
   logic [1:0]                    rresp;
   logic                          rvalid;
   logic                          rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/rr_arbiter.sv
// Two-way round-robin arbiter: one-hot grant from the request vector, with the
// priority pointer moving away from the winner whenever a grant is accepted.
module rr_arbiter
   import eth_reg_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_accept,
   output logic [NUM_REQ-1:0] o_grant
);

   logic r_prio;

   // r_prio set means requester 1 wins a tie
   always_comb begin
      o_grant = '0;
      case (i_req)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = r_prio ? 2'b10 : 2'b01;
         default: o_grant = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio <= 1'b0;
      end else if (i_accept) begin
         r_prio <= o_grant[0];
      end
   end

endmodule

// File: rtl/eth_reg_arbiter.sv
// Serialises register accesses from two requesters onto one AXI-Lite master,
// one transaction at a time through IDLE -> ADDR -> RESP -> DONE.
module eth_reg_arbiter
   import eth_reg_pkg::*;
#(
   parameter int P_AXI_ADDR_WIDTH = 13,
   parameter int P_AXI_DATA_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   eth_req_if.slave   req,
   eth_axil_if.master m_axi
);

   localparam int LP_AW = P_AXI_ADDR_WIDTH;
   localparam int LP_DW = P_AXI_DATA_WIDTH;
   localparam int LP_SW = P_AXI_DATA_WIDTH/8;

   state_t             r_state;
   logic               r_sel;
   logic               r_write;
   logic [LP_AW-1:0]   r_addr;
   logic [LP_DW-1:0]   r_wdata;
   logic [LP_SW-1:0]   r_wstrb;
   logic               r_awvalid;
   logic               r_wvalid;
   logic               r_bready;
   logic               r_arvalid;
   logic               r_rready;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [LP_DW-1:0]   r_rsp_rdata;
   logic [1:0]         r_rsp_resp;

   logic [NUM_REQ-1:0] w_grant;
   logic               w_accept;
   logic               w_idx;
   logic               w_write;
   logic [LP_AW-1:0]   w_addr;
   logic [LP_DW-1:0]   w_wdata;
   logic [LP_SW-1:0]   w_wstrb;
   logic               w_addr_done;

   assign w_accept = !rst && (r_state == ST_IDLE) && (|req.req_valid);
   assign w_idx    = w_grant[1];
   assign w_write  = w_idx ? req.req_write[1] : req.req_write[0];
   assign w_addr   = w_idx ? req.req_addr[2*LP_AW-1:LP_AW]   : req.req_addr[LP_AW-1:0];
   assign w_wdata  = w_idx ? req.req_wdata[2*LP_DW-1:LP_DW]  : req.req_wdata[LP_DW-1:0];
   assign w_wstrb  = w_idx ? req.req_wstrb[2*LP_SW-1:LP_SW]  : req.req_wstrb[LP_SW-1:0];

   // AW and W complete independently; a channel is done once its valid has dropped
   assign w_addr_done = (!r_awvalid || m_axi.awready) && (!r_wvalid || m_axi.wready);

   rr_arbiter u_rr_arbiter (
      .clk      (clk),
      .rst      (rst),
      .i_req    (req.req_valid),
      .i_accept (w_accept),
      .o_grant  (w_grant)
   );

   assign req.req_ready = w_accept ? w_grant : '0;
   assign req.rsp_valid = r_rsp_valid;
   assign req.rsp_rdata = r_rsp_rdata;
   assign req.rsp_resp  = r_rsp_resp;
   assign req.busy      = (r_state != ST_IDLE);

   assign m_axi.awaddr  = r_addr;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = r_awvalid;
   assign m_axi.wdata   = r_wdata;
   assign m_axi.wstrb   = r_wstrb;
   assign m_axi.wvalid  = r_wvalid;
   assign m_axi.bready  = r_bready;
   assign m_axi.araddr  = r_addr;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arvalid = r_arvalid;
   assign m_axi.rready  = r_rready;

   // Command fields are latched only at grant, so they carry no reset value
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_sel     <= w_idx;
                  r_write   <= w_write;
                  r_addr    <= w_addr;
                  r_wdata   <= w_wdata;
                  r_wstrb   <= w_wstrb;
                  r_awvalid <= w_write;
                  r_wvalid  <= w_write;
                  r_arvalid <= !w_write;
                  r_state   <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (r_write) begin
                  if (m_axi.awready) r_awvalid <= 1'b0;
                  if (m_axi.wready)  r_wvalid  <= 1'b0;
                  if (w_addr_done) begin
                     r_bready <= 1'b1;
                     r_state  <= ST_RESP;
                  end
               end else if (m_axi.arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (r_write && m_axi.bvalid) begin
                  r_bready    <= 1'b0;
                  r_rsp_resp  <= m_axi.bresp;
                  r_rsp_rdata <= '0;
                  r_rsp_valid <= r_sel ? 2'b10 : 2'b01;
                  r_state     <= ST_DONE;
               end else if (!r_write && m_axi.rvalid) begin
                  r_rready    <= 1'b0;
                  r_rsp_resp  <= m_axi.rresp;
                  r_rsp_rdata <= m_axi.rdata;
                  r_rsp_valid <= r_sel ? 2'b10 : 2'b01;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_rsp_valid <= '0;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_reg_arbiter.sv
// Bench for eth_reg_arbiter: directed scenarios then random traffic, with a
// latency-programmable AXI-Lite slave and a round-robin reference model.
module tb_eth_reg_arbiter;
   import eth_reg_pkg::*;

   localparam int AW = 13;
   localparam int DW = 32;
   localparam int SW = DW/8;

   logic clk;
   logic rst;

   eth_req_if  #(.P_AXI_ADDR_WIDTH(AW), .P_AXI_DATA_WIDTH(DW)) reqBus ();
   eth_axil_if #(.P_AXI_ADDR_WIDTH(AW), .P_AXI_DATA_WIDTH(DW)) axiBus ();

   eth_reg_arbiter #(.P_AXI_ADDR_WIDTH(AW), .P_AXI_DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (reqBus.slave),
      .m_axi (axiBus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nAsserts = 0;
   int nFail    = 0;
   int lastGrant;

   logic          cmdWrite [2];
   logic [AW-1:0] cmdAddr  [2];
   logic [DW-1:0] cmdWdata [2];
   logic [SW-1:0] cmdWstrb [2];

   int            cfgAwLat, cfgWLat, cfgArLat, cfgBLat, cfgRLat;
   logic [1:0]    cfgBresp, cfgRresp;
   logic [DW-1:0] cfgRdata;

   int            awAge, wAge, arAge, bAge, rAge;
   bit            awCommit, wCommit, arCommit, bCommit, rCommit;
   bit            awDone, wDone, bPending, rPending, slaveClear;
   int            addrDoneCnt, bHs, arHs, rHs;
   logic [AW-1:0] capAwaddr, capAraddr, firstAwaddr, firstAraddr;
   logic [DW-1:0] capWdata, firstWdata;
   logic [SW-1:0] capWstrb, firstWstrb;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] mask);
      reqBus.req_write = {cmdWrite[1], cmdWrite[0]};
      reqBus.req_addr  = {cmdAddr[1],  cmdAddr[0]};
      reqBus.req_wdata = {cmdWdata[1], cmdWdata[0]};
      reqBus.req_wstrb = {cmdWstrb[1], cmdWstrb[0]};
      reqBus.req_valid = mask;
   endtask

   // Slave: each ready or response valid appears after its programmed wait;
   // bready/rready must be high exactly between the address phase and the response.
   initial begin
      axiBus.awready = 0; axiBus.wready = 0; axiBus.arready = 0;
      axiBus.bvalid = 0;  axiBus.bresp = 0;
      axiBus.rvalid = 0;  axiBus.rresp = 0;  axiBus.rdata = 0;
      forever begin
         @(posedge clk); #2;
         if (slaveClear) begin
            axiBus.awready = 0; axiBus.wready = 0; axiBus.arready = 0;
            axiBus.bvalid = 0;  axiBus.rvalid = 0;
            {awCommit, wCommit, arCommit, bCommit, rCommit} = '0;
            {awDone, wDone, bPending, rPending} = '0;
            addrDoneCnt = 0; bHs = 0; arHs = 0; rHs = 0;
            awAge = 0; wAge = 0; arAge = 0;
            slaveClear = 0;
         end
         checkOutput("bready_window", axiBus.bready, addrDoneCnt > bHs);
         checkOutput("rready_window", axiBus.rready, arHs > rHs);
         if (awCommit) begin checkOutput("awvalid_drop", axiBus.awvalid, 0); axiBus.awready = 0; awCommit = 0; end
         if (wCommit)  begin checkOutput("wvalid_drop",  axiBus.wvalid,  0); axiBus.wready  = 0; wCommit  = 0; end
         if (arCommit) begin checkOutput("arvalid_drop", axiBus.arvalid, 0); axiBus.arready = 0; arCommit = 0; end
         if (bCommit)  begin axiBus.bvalid = 0; bCommit = 0; end
         if (rCommit)  begin axiBus.rvalid = 0; rCommit = 0; end

         if (axiBus.awvalid) begin
            if (awAge == 0) firstAwaddr = axiBus.awaddr;
            else checkOutput("awaddr_stable", axiBus.awaddr, firstAwaddr);
            if (awAge >= cfgAwLat) begin
               axiBus.awready = 1; awCommit = 1; awDone = 1; capAwaddr = axiBus.awaddr;
            end
            awAge++;
         end else awAge = 0;

         if (axiBus.wvalid) begin
            if (wAge == 0) begin firstWdata = axiBus.wdata; firstWstrb = axiBus.wstrb; end
            else checkOutput("wdata_stable", {axiBus.wstrb, axiBus.wdata}, {firstWstrb, firstWdata});
            if (wAge >= cfgWLat) begin
               axiBus.wready = 1; wCommit = 1; wDone = 1;
               capWdata = axiBus.wdata; capWstrb = axiBus.wstrb;
            end
            wAge++;
         end else wAge = 0;

         if (awDone && wDone) begin
            awDone = 0; wDone = 0; addrDoneCnt++; bPending = 1; bAge = 0;
         end

         if (axiBus.arvalid) begin
            if (arAge == 0) firstAraddr = axiBus.araddr;
            else checkOutput("araddr_stable", axiBus.araddr, firstAraddr);
            if (arAge >= cfgArLat) begin
               axiBus.arready = 1; arCommit = 1; capAraddr = axiBus.araddr;
               arHs++; rPending = 1; rAge = 0;
            end
            arAge++;
         end else arAge = 0;

         if (bPending) begin
            if (bAge >= cfgBLat) begin axiBus.bvalid = 1; axiBus.bresp = cfgBresp; bPending = 0; end
            else bAge++;
         end
         if (axiBus.bvalid && axiBus.bready) begin bCommit = 1; bHs++; end

         if (rPending) begin
            if (rAge >= cfgRLat) begin
               axiBus.rvalid = 1; axiBus.rresp = cfgRresp; axiBus.rdata = cfgRdata; rPending = 0;
            end else rAge++;
         end
         if (axiBus.rvalid && axiBus.rready) begin rCommit = 1; rHs++; end
      end
   end

   // One arbitrated transaction: expected winner from round-robin rules,
   // expected latency from the slave's programmed waits.
   task automatic serveOne(input logic [1:0] mask, input bit dropAll);
      int  g, lat, expLat, a, r;
      bit  got;
      g = (mask == 2'b11) ? 1 - lastGrant : ((mask == 2'b01) ? 0 : 1);
      got = 0;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (reqBus.req_ready != 0) begin got = 1; break; end
         @(negedge clk);
      end
      checkOutput("grant_seen", got, 1);
      if (!got) return;
      checkOutput("grant_onehot", reqBus.req_ready, (g == 0) ? 2'b01 : 2'b10);
      lastGrant = g;
      if (cmdWrite[g]) begin
         a = ((cfgAwLat > cfgWLat) ? cfgAwLat : cfgWLat) + 1;
         r = (cfgBLat > 1) ? cfgBLat : 1;
      end else begin
         a = cfgArLat + 1;
         r = (cfgRLat > 1) ? cfgRLat : 1;
      end
      expLat = a + r + 1;
      lat = 0;
      got = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            checkOutput("busy_active", reqBus.busy, 1);
            checkOutput("first_addr_valids", {axiBus.awvalid, axiBus.wvalid, axiBus.arvalid},
                        cmdWrite[g] ? 3'b110 : 3'b001);
            if (dropAll) reqBus.req_valid = 2'b00;
         end
         if (reqBus.rsp_valid != 0) begin got = 1; break; end
      end
      checkOutput("rsp_seen", got, 1);
      checkOutput("rsp_latency", lat, expLat);
      checkOutput("rsp_valid_owner", reqBus.rsp_valid, (g == 0) ? 2'b01 : 2'b10);
      if (cmdWrite[g]) begin
         checkOutput("rsp_resp_wr", reqBus.rsp_resp, cfgBresp);
         checkOutput("rsp_rdata_wr_zero", reqBus.rsp_rdata, 0);
         checkOutput("awaddr_sent", capAwaddr, cmdAddr[g]);
         checkOutput("wdata_sent", capWdata, cmdWdata[g]);
         checkOutput("wstrb_sent", capWstrb, cmdWstrb[g]);
      end else begin
         checkOutput("rsp_resp_rd", reqBus.rsp_resp, cfgRresp);
         checkOutput("rsp_rdata_rd", reqBus.rsp_rdata, cfgRdata);
         checkOutput("araddr_sent", capAraddr, cmdAddr[g]);
      end
      @(negedge clk);
      checkOutput("rsp_valid_pulse", reqBus.rsp_valid, 0);
      checkOutput("busy_idle", reqBus.busy, 0);
      if (dropAll) checkOutput("no_stray_grant", reqBus.req_ready, 0);
   endtask

   initial begin
      int bBefore;
      bit got;
      logic [1:0] mask;
      rst = 1;
      slaveClear = 0;
      addrDoneCnt = 0; bHs = 0; arHs = 0; rHs = 0;
      {awCommit, wCommit, arCommit, bCommit, rCommit} = '0;
      {awDone, wDone, bPending, rPending} = '0;
      awAge = 0; wAge = 0; arAge = 0; bAge = 0; rAge = 0;
      cfgAwLat = 0; cfgWLat = 0; cfgArLat = 0; cfgBLat = 0; cfgRLat = 0;
      cfgBresp = RESP_OKAY; cfgRresp = RESP_OKAY; cfgRdata = '0;
      for (int i = 0; i < 2; i++) begin
         cmdWrite[i] = 0; cmdAddr[i] = '0; cmdWdata[i] = '0; cmdWstrb[i] = '0;
      end
      applyStimulus(2'b00);
      lastGrant = 1;
      repeat (3) @(negedge clk);

      // Reset state, including no grant while reset is held
      checkOutput("reset_busy", reqBus.busy, 0);
      checkOutput("reset_rsp_valid", reqBus.rsp_valid, 0);
      checkOutput("reset_rsp", {reqBus.rsp_resp, reqBus.rsp_rdata}, 0);
      checkOutput("reset_axi_ctl", {axiBus.awvalid, axiBus.wvalid, axiBus.bready, axiBus.arvalid, axiBus.rready}, 0);
      applyStimulus(2'b11);
      #1;
      checkOutput("reset_no_ready", reqBus.req_ready, 0);
      @(negedge clk);
      applyStimulus(2'b00);
      rst = 0;
      @(negedge clk);

      // Single write from r0, minimum latency
      cmdWrite[0] = 1; cmdAddr[0] = 13'h07F4; cmdWdata[0] = 32'h0000_0009; cmdWstrb[0] = 4'hF;
      applyStimulus(2'b01);
      serveOne(2'b01, 1);

      // Single read from r1 with a slow R channel
      cmdWrite[1] = 0; cmdAddr[1] = 13'h07FC;
      cfgRLat = 5; cfgRdata = 32'hDEAD_BEEF;
      applyStimulus(2'b10);
      serveOne(2'b10, 1);
      cfgRLat = 0;

      // Split handshake: W accepted three cycles before AW
      cmdWrite[0] = 1; cmdAddr[0] = 13'h0123; cmdWdata[0] = 32'hA5A5_5A5A; cmdWstrb[0] = 4'h6;
      cfgWLat = 0; cfgAwLat = 3; cfgBLat = 2;
      bBefore = bHs;
      applyStimulus(2'b01);
      serveOne(2'b01, 1);
      repeat (2) @(negedge clk);
      checkOutput("split_one_b", bHs - bBefore, 1);
      cfgAwLat = 0; cfgBLat = 0;

      // Error responses pass straight through
      cmdWrite[1] = 1; cmdAddr[1] = 13'h1004; cmdWdata[1] = 32'h1; cmdWstrb[1] = 4'h1;
      cfgBresp = RESP_SLVERR;
      applyStimulus(2'b10);
      serveOne(2'b10, 1);
      cmdWrite[1] = 0; cmdAddr[1] = 13'h1FF0;
      cfgRresp = RESP_DECERR; cfgRdata = 32'h1357_9BDF;
      applyStimulus(2'b10);
      serveOne(2'b10, 1);
      cfgBresp = RESP_OKAY; cfgRresp = RESP_OKAY;

      // Reset while waiting in RESP aborts silently and rewinds the pointer
      cmdWrite[0] = 1; cmdAddr[0] = 13'h0040; cmdWdata[0] = 32'hFFFF_0000; cmdWstrb[0] = 4'hC;
      cfgBLat = 40;
      applyStimulus(2'b01);
      #1;
      checkOutput("abort_grant", reqBus.req_ready, 2'b01);
      lastGrant = 0;
      @(negedge clk);
      applyStimulus(2'b00);
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if (axiBus.bready) begin got = 1; break; end
         @(negedge clk);
      end
      checkOutput("abort_reached_resp", got, 1);
      rst = 1;
      slaveClear = 1;
      lastGrant = 1;
      @(negedge clk);
      checkOutput("abort_busy", reqBus.busy, 0);
      checkOutput("abort_req_ready", reqBus.req_ready, 0);
      checkOutput("abort_rsp_valid", reqBus.rsp_valid, 0);
      checkOutput("abort_rsp_rdata", reqBus.rsp_rdata, 0);
      checkOutput("abort_rsp_resp", reqBus.rsp_resp, 0);
      checkOutput("abort_axi_ctl", {axiBus.awvalid, axiBus.wvalid, axiBus.bready, axiBus.arvalid, axiBus.rready}, 0);
      @(negedge clk);
      rst = 0;
      cfgBLat = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("abort_no_rsp", reqBus.rsp_valid, 0);
      end

      // Contention: both held valid for four transactions
      cmdWrite[0] = 0; cmdAddr[0] = 13'h0100;
      cmdWrite[1] = 0; cmdAddr[1] = 13'h0200;
      cfgRdata = 32'h0BAD_F00D;
      applyStimulus(2'b11);
      for (int i = 0; i < 4; i++) serveOne(2'b11, 0);
      applyStimulus(2'b00);
      @(negedge clk);

      // Random traffic
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < 2; i++) begin
            cmdWrite[i] = 1'($urandom_range(0, 1));
            cmdAddr[i]  = AW'($urandom);
            cmdWdata[i] = DW'($urandom);
            cmdWstrb[i] = SW'($urandom_range(1, 15));
         end
         cfgAwLat = $urandom_range(0, 4); cfgWLat = $urandom_range(0, 4);
         cfgArLat = $urandom_range(0, 4); cfgBLat = $urandom_range(0, 4);
         cfgRLat  = $urandom_range(0, 4);
         cfgBresp = 2'($urandom_range(0, 3)); cfgRresp = 2'($urandom_range(0, 3));
         cfgRdata = DW'($urandom);
         mask = 2'($urandom_range(1, 3));
         applyStimulus(mask);
         serveOne(mask, 1);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
